// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and parity helper for the UART receiver.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return (^d) ^ (mode == PARITY_ODD);
    endfunction
endpackage

// File: rtl/uart_rx_sync_filter.sv
// uart_rx_sync_filter: 2-flop line synchronizer plus 3-sample mid-bit majority voter.
module uart_rx_sync_filter #(
    parameter int OVERSAMPLE = 16,
    localparam int TW = $clog2(OVERSAMPLE)
) (
    input  logic          rx_clk,
    input  logic          reset_n,
    input  logic          rx_in,
    input  logic          tick,
    input  logic [TW-1:0] tcnt,
    output logic          rx_sync,
    output logic          mid_bit
);
    logic meta, s0, s1;
    always_ff @(posedge rx_clk) begin
        if (!reset_n) begin
            meta    <= 1'b1;
            rx_sync <= 1'b1;
            s0      <= 1'b1;
            s1      <= 1'b1;
        end else begin
            meta    <= rx_in;
            rx_sync <= meta;
            if (tick && tcnt == TW'(OVERSAMPLE/2-1)) s0 <= rx_sync;
            if (tick && tcnt == TW'(OVERSAMPLE/2)) s1 <= rx_sync;
        end
    end
    // third vote is the live sample, valid on the tick at OVERSAMPLE/2+1
    assign mid_bit = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receive frame engine with parity, stop checks
// and a valid/ready output register with sticky overrun.
module uart_rx_frame import uart_pkg::*; #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic                 rx_in,
    input  logic                 tick,
    input  logic                 data_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2+1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE-1);
    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic scnt;
    logic [DATA_BITS-1:0] shreg;
    logic perr_l, ferr_l, rx_sync, mid_bit, at_mid, at_wrap, done, frame_bad;
    uart_rx_sync_filter #(.OVERSAMPLE(OVERSAMPLE)) u_sync (
        .rx_clk(rx_clk),
        .reset_n(reset_n),
        .rx_in(rx_in),
        .tick(tick),
        .tcnt(tcnt),
        .rx_sync(rx_sync),
        .mid_bit(mid_bit)
    );
    assign at_mid    = tick && tcnt == T_MID;
    assign at_wrap   = tick && tcnt == T_LAST;
    assign frame_bad = ferr_l | ~mid_bit;
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            IDLE:     if (tick && !rx_sync) state_n = START;
            START:    state_n = (at_mid && mid_bit) ? IDLE : at_wrap ? DATA : START;
            DATA:     if (at_wrap && bcnt == BW'(DATA_BITS-1))
                          state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            PARITY:   if (at_wrap) state_n = STOP;
            STOP:     if (at_mid && scnt == 1'(STOP_BITS-1)) begin
                          done    = 1'b1;
                          state_n = frame_bad ? BRK_WAIT : IDLE;
                      end
            BRK_WAIT: if (tick && rx_sync) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge rx_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            bcnt       <= '0;
            scnt       <= 1'b0;
            shreg      <= '0;
            perr_l     <= 1'b0;
            ferr_l     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                tcnt   <= '0;
                bcnt   <= '0;
                scnt   <= 1'b0;
                perr_l <= 1'b0;
                ferr_l <= 1'b0;
            end else if (tick) begin
                tcnt <= at_wrap ? '0 : tcnt + 1'b1;
            end
            if (state == DATA && at_mid) shreg <= {mid_bit, shreg[DATA_BITS-1:1]};
            if (state == DATA && at_wrap) bcnt <= bcnt + 1'b1;
            if (state == PARITY && at_mid) perr_l <= mid_bit != parity_bit(9'(shreg), PARITY_MODE);
            if (state == STOP && at_mid && !mid_bit) ferr_l <= 1'b1;
            if (state == STOP && at_wrap) scnt <= 1'b1;
            // a completing frame may load in the same cycle the consumer drains the register
            if (done && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                parity_err <= perr_l;
                frame_err  <= frame_bad;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            overrun <= (overrun & ~err_clr) | (done & data_valid & ~data_ready);
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames into three receiver configurations with hand-computed results.
module tb_uart_rx_frame;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;
    logic tick = 1'b1;
    logic err_clr = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] dr = 3'b000;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic v0, pe0, fe0, ov0, b0;
    logic v1, pe1, fe1, ov1, b1;
    logic v2, pe2, fe2, ov2, b2;
    int checks = 0;
    int errors = 0;

    uart_rx_frame u0 (
        .rx_clk(clk), .reset_n(reset_n), .rx_in(rx[0]), .tick(tick),
        .data_ready(dr[0]), .err_clr(err_clr), .data_out(d0), .data_valid(v0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0)
    );
    uart_rx_frame #(.PARITY_MODE(1)) u1 (
        .rx_clk(clk), .reset_n(reset_n), .rx_in(rx[1]), .tick(tick),
        .data_ready(dr[1]), .err_clr(err_clr), .data_out(d1), .data_valid(v1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1)
    );
    uart_rx_frame #(.DATA_BITS(9), .STOP_BITS(2), .PARITY_MODE(2)) u2 (
        .rx_clk(clk), .reset_n(reset_n), .rx_in(rx[2]), .tick(tick),
        .data_ready(dr[2]), .err_clr(err_clr), .data_out(d2), .data_valid(v2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int db, input int np,
                              input logic pb, input logic [1:0] st, input int ns);
        logic [15:0] f;
        int n;
        f = '0;
        for (int i = 0; i < db; i++) f[1+i] = d[i];
        n = 1 + db;
        if (np != 0) begin
            f[n] = pb;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            f[n] = st[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx[sel] = f[i];
            repeat (15) @(negedge clk);
        end
    endtask

    task automatic hs(input int sel);
        @(negedge clk);
        dr[sel] = 1'b1;
        @(negedge clk);
        dr[sel] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        check("rst_valid", 16'(v0), 16'h0);
        check("rst_data", 16'(d0), 16'h0);
        check("rst_overrun", 16'(ov0), 16'h0);
        check("rst_busy", 16'(b0), 16'h0);
        reset_n = 1'b1;
        idle(5);
        // valid must rise on the edge that follows the stop mid-sample tick
        fork
            send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
            begin
                repeat (157) @(negedge clk);
                check("t1_valid_early", 16'(v0), 16'h0);
                @(negedge clk);
                check("t1_valid_rise", 16'(v0), 16'h1);
            end
        join
        check("t1_data", 16'(d0), 16'h00A5);
        check("t1_perr", 16'(pe0), 16'h0);
        check("t1_ferr", 16'(fe0), 16'h0);
        check("t1_busy", 16'(b0), 16'h0);
        hs(0);
        check("t1_drain", 16'(v0), 16'h0);
        check("t1_hold", 16'(d0), 16'h00A5);

        @(negedge clk);
        rx[0] = 1'b0;
        idle(4);
        check("t2_busy_start", 16'(b0), 16'h1);
        rx[0] = 1'b1;
        for (int k = 0; k < 16 && b0; k++) @(negedge clk);
        check("t2_busy_end", 16'(b0), 16'h0);
        check("t2_no_valid", 16'(v0), 16'h0);

        send_frame(1, 9'h03C, 8, 1, 1'b1, 2'b11, 1);
        idle(2);
        check("t3_data_bad", 16'(d1), 16'h003C);
        check("t3_perr_bad", 16'(pe1), 16'h1);
        check("t3_ferr", 16'(fe1), 16'h0);
        hs(1);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 2'b11, 1);
        idle(2);
        check("t3_valid_ok", 16'(v1), 16'h1);
        check("t3_perr_ok", 16'(pe1), 16'h0);
        hs(1);

        send_frame(0, 9'h033, 8, 0, 1'b0, 2'b10, 1);
        idle(48);
        check("t4_valid", 16'(v0), 16'h1);
        check("t4_data", 16'(d0), 16'h0033);
        check("t4_ferr", 16'(fe0), 16'h1);
        check("t4_brk_busy", 16'(b0), 16'h1);
        check("t4_no_ovr", 16'(ov0), 16'h0);
        hs(0);
        @(negedge clk);
        rx[0] = 1'b1;
        idle(16);
        check("t4_idle", 16'(b0), 16'h0);
        check("t4_no_word", 16'(v0), 16'h0);
        send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1);
        idle(2);
        check("t4_data2", 16'(d0), 16'h007E);
        check("t4_ferr2", 16'(fe0), 16'h0);
        hs(0);

        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
        idle(2);
        check("t5_keep", 16'(d0), 16'h0011);
        check("t5_ovr", 16'(ov0), 16'h1);
        hs(0);
        check("t5_drain", 16'(v0), 16'h0);
        check("t5_ovr_sticky", 16'(ov0), 16'h1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_ovr_clr", 16'(ov0), 16'h0);
        send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
        fork
            send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
            begin
                repeat (157) @(negedge clk);
                dr[0] = 1'b1;
                @(negedge clk);
                dr[0] = 1'b0;
            end
        join
        check("t5_swap_data", 16'(d0), 16'h0022);
        check("t5_swap_valid", 16'(v0), 16'h1);
        check("t5_swap_ovr", 16'(ov0), 16'h0);

        // data bits 3..7 are 1 so the line stays idle after the abandoned frame
        fork
            send_frame(0, 9'h0F8, 8, 0, 1'b0, 2'b11, 1);
            begin
                repeat (72) @(negedge clk);
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                check("t6_valid", 16'(v0), 16'h0);
                check("t6_data", 16'(d0), 16'h0);
                check("t6_busy", 16'(b0), 16'h0);
                check("t6_flags", 16'({pe0, fe0, ov0}), 16'h0);
            end
        join
        idle(4);
        check("t6_abandon", 16'(v0), 16'h0);
        send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1);
        idle(2);
        check("t6_data2", 16'(d0), 16'h005A);
        check("t6_valid2", 16'(v0), 16'h1);
        hs(0);

        send_frame(2, 9'h1A3, 9, 1, 1'b0, 2'b11, 2);
        idle(2);
        check("t7_data", 16'(d2), 16'h01A3);
        check("t7_flags", 16'({pe2, fe2}), 16'h0);
        check("t7_valid", 16'(v2), 16'h1);
        hs(2);
        send_frame(2, 9'h1A3, 9, 1, 1'b0, 2'b01, 2);
        idle(2);
        check("t7_ferr", 16'(fe2), 16'h1);
        check("t7_perr", 16'(pe2), 16'h0);
        check("t7_data2", 16'(d2), 16'h01A3);
        @(negedge clk);
        rx[2] = 1'b1;
        idle(20);
        check("t7_idle", 16'(b2), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
